dual_lane_deser: RTL
====================

DUAL_LANE_DESER -- requirements
Module: dual_lane_deser

Interface
REQ-001 Parameters: DEPTH, 4, output FIFO entries (power of two, >=2); CNT_W, 16, delivered-byte counter width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 lane1_in  input  1  lane-1 bit from upstream sub-module dout1.
REQ-005 lane2_in  input  1  lane-2 bit from upstream sub-module dout2.
REQ-006 in_vld  input  1  both lanes hold a valid sample this cycle.
REQ-007 align  input  1  sampled with in_vld; current sample begins a new byte.
REQ-008 out_vld  output  1  out_data holds a valid byte.
REQ-009 out_rdy  input  1  consumer accepts byte when out_vld and out_rdy are both high.
REQ-010 out_data  output  8  FIFO head byte.
REQ-011 ovf  output  1  sticky overflow flag.
REQ-012 ovf_clr  input  1  clears ovf.

Function
REQ-013 Sample k (0..3) of a byte: data[2k] = lane1_in, data[2k+1] = lane2_in, LSB first.
REQ-014 Assembler FSM states: IDLE (no partial byte), COLLECT (1-3 samples held).
REQ-015 Transitions: IDLE->COLLECT on in_vld; COLLECT->IDLE when the 4th sample is taken; otherwise hold; no transition without in_vld.
REQ-016 in_vld with align: discard any partial byte; this sample is sample 0; FSM goes to COLLECT.
REQ-017 A completed byte is pushed into the FIFO on the edge that captures the 4th sample.
REQ-018 out_vld rises in the cycle after that edge (1-cycle latency); out_data is registered FIFO-head data.
REQ-019 FIFO is in-order; out_vld = not empty; out_data is don't-care when out_vld is low but holds stable while out_vld is high and out_rdy is low.
REQ-020 Pop occurs on an out_vld & out_rdy edge; a push and pop in the same cycle are both honoured at any occupancy, including full.
REQ-021 Push while full without a same-cycle pop: the byte is dropped, FIFO contents are unchanged, and ovf sets on that edge.
REQ-022 ovf stays set until an ovf_clr edge; if set and clear coincide, set wins.
REQ-023 Read and write pointers wrap modulo DEPTH; full/empty use an extra pointer MSB.

Reset
REQ-024 On rst_n low, immediately and asynchronously: FSM=IDLE, sample count=0, FIFO empty, out_vld=0, out_data=8'h00, ovf=0, word_cnt=0.
REQ-025 Reset mid-byte discards the partial byte; reset with FIFO non-empty discards all entries.
REQ-026 The first sample after rst_n release is sample 0 regardless of align.

Configuration
REQ-027 Macro DUAL_LANE_DESER_CNT_EN: when defined, add output word_cnt [CNT_W-1:0], incremented on each pop, wrapping to 0 after all-ones.
REQ-028 Without DUAL_LANE_DESER_CNT_EN: word_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-029 After reset, out_rdy=1, 4 in_vld samples (l1,l2)=(1,0),(0,1),(1,1),(0,0) -> out_vld=1 one cycle after the 4th edge, out_data=8'h39.
REQ-030 out_rdy=0, push 5 bytes 8'h01..8'h05 -> 5th dropped, ovf=1; then out_rdy=1 -> pops 01,02,03,04 in order, ovf remains 1 until ovf_clr.
REQ-031 FIFO full, out_rdy=1, 4th sample completes in the same cycle as a pop -> no drop, ovf=0, occupancy stays 4.
REQ-032 2 samples taken, then in_vld+align with (1,1) followed by 3 samples of (0,0) -> byte 8'h03; partial byte discarded.
REQ-033 rst_n pulsed low asynchronously after sample 2 with 2 bytes queued -> out_vld=0 immediately; next 4 samples produce a fresh byte.
REQ-034 With DUAL_LANE_DESER_CNT_EN and CNT_W=4: 17 pops -> word_cnt=1 (wrapped); without the macro: port absent, compile clean.

Source files
------------

// File: rtl/dual_lane_deser_if.sv
// Dual-lane deserializer bus interface.
// Groups the upstream sample lanes, the byte output handshake and the
// overflow flag/clear.
//   master : upstream producer + downstream consumer side (drives samples, out_rdy, ovf_clr)
//   slave  : the deserializer (drives out_vld, out_data, ovf)
interface dual_lane_deser_if;
  logic       lane1_in;
  logic       lane2_in;
  logic       in_vld;
  logic       align;
  logic       out_vld;
  logic       out_rdy;
  logic [7:0] out_data;
  logic       ovf;
  logic       ovf_clr;

  modport master (
    output lane1_in, lane2_in, in_vld, align, out_rdy, ovf_clr,
    input  out_vld, out_data, ovf
  );

  modport slave (
    input  lane1_in, lane2_in, in_vld, align, out_rdy, ovf_clr,
    output out_vld, out_data, ovf
  );
endinterface

// File: rtl/dual_lane_deser.sv
// Dual-lane deserializer: packs 2-bit samples (lane1 -> even bit, lane2 -> odd
// bit, LSB first) into bytes and queues them in a DEPTH-entry in-order FIFO
// with a registered head output and a sticky overflow flag.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : lane1_in, lane2_in, in_vld, align, out_vld, out_rdy,
//                     out_data[7:0], ovf, ovf_clr
//   word_cnt        : delivered-byte counter, present only when the macro
//                     DUAL_LANE_DESER_CNT_EN is defined
module dual_lane_deser #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dual_lane_deser_if.slave     bus
`ifdef DUAL_LANE_DESER_CNT_EN
  ,
  output logic [CNT_W-1:0]     word_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [7:0]         part_q, part_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               out_vld_q, out_vld_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         mem_q [DEPTH];

  logic [1:0]         idx;
  logic               push_req;
  logic [7:0]         push_byte;
  logic               full, empty, pop, push_ok, ovf_set;
  logic [IDX_W-1:0]   wr_idx, rd_idx_d;

  // Byte assembler: align or an empty assembler restarts at sample 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    part_d    = part_q;
    idx       = 2'd0;
    push_req  = 1'b0;
    push_byte = part_q;
    if (bus.in_vld) begin
      if (bus.align || state_q == IDLE) begin
        idx    = 2'd0;
        part_d = 8'h00;
      end else begin
        idx = cnt_q;
      end
      part_d[{idx, 1'b0}] = bus.lane1_in;
      part_d[{idx, 1'b1}] = bus.lane2_in;
      if (idx == 2'd3) begin
        push_req  = 1'b1;
        push_byte = part_d;
        state_d   = IDLE;
        cnt_d     = 2'd0;
        part_d    = 8'h00;
      end else begin
        state_d = COLLECT;
        cnt_d   = 2'(idx + 2'd1);
      end
    end
  end

  // FIFO control; a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
               (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
    pop      = !empty && bus.out_rdy;
    push_ok  = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_idx   = wr_ptr_q[IDX_W-1:0];
    rd_idx_d = rd_ptr_d[IDX_W-1:0];
    out_vld_d = (wr_ptr_d != rd_ptr_d);
    // Next head is the byte being written when it lands in the head slot.
    out_data_d = (push_ok && wr_idx == rd_idx_d) ? push_byte : mem_q[rd_idx_d];
    // Set wins over a coincident clear.
    ovf_d = ovf_set ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      part_q     <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= 8'h00;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      part_q     <= part_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_idx] <= push_byte;
  end

  assign bus.out_vld  = out_vld_q;
  assign bus.out_data = out_data_q;
  assign bus.ovf      = ovf_q;

`ifdef DUAL_LANE_DESER_CNT_EN
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  // Delivered-byte counter, wraps naturally.
  always_comb begin
    word_cnt_d = word_cnt_q + CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_cnt_q <= '0;
    else        word_cnt_q <= word_cnt_d;
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule
